// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int STAT_W = 16;

   // Index width for n items; never less than one bit.
   function automatic int clog2_f(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         w = ((32'sd1 << i) < n) ? i + 1 : w;
      end
      return w;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin winner selection: rotate the request vector so the search starts
// just after the last grant, priority-encode, then rotate the index back.
module fifo_wr_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int GID_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   last,
   output logic [GID_W-1:0]   winner,
   output logic               valid
);

   logic [GID_W-1:0]   start_s;
   logic [NUM_REQ-1:0] rot_s;
   logic [GID_W-1:0]   off_s;

   // search starts one past the previous grant, wrapping to 0
   always_comb begin
      if (int'(last) >= NUM_REQ - 1) begin
         start_s = '0;
      end else begin
         start_s = last + 1'b1;
      end
   end

   // rot_s[i] holds the request at position start_s + i (mod NUM_REQ)
   always_comb begin
      rot_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            rot_s[i] = rot_s[i] | (req[j] & (((int'(start_s) + i) % NUM_REQ) == j));
         end
      end
   end

   // lowest rotated bit wins; map its offset back to a producer index
   always_comb begin
      off_s = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? GID_W'(i) : off_s;
      end
      winner = GID_W'((int'(start_s) + int'(off_s)) % NUM_REQ);
      valid  = |req;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with
// bounded bursts and full backpressure. Optional per-producer counters: WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   parameter int  DATA_W    = 8,
   parameter int  BURST_LEN = 4,
   localparam int GID_W     = clog2_f(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_din,
   output logic [GID_W-1:0]          grant_id,
   output logic                      busy
`ifdef WR_ARB_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

   localparam int               CNT_W    = clog2_f(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [GID_W-1:0] GID_RST  = GID_W'(NUM_REQ - 1);

   state_t             state_r, state_nxt;
   logic [GID_W-1:0]   grant_id_r, grant_id_nxt;
   logic [CNT_W-1:0]   burst_cnt_r, burst_cnt_nxt;
   logic [GID_W-1:0]   pick_id_s;
   logic               pick_vld_s;
   logic               sel_req_s;
   logic               xfer_s;

   fifo_wr_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GID_W   (GID_W)
   ) u_rr_pick (
      .req     (req),
      .last    (grant_id_r),
      .winner  (pick_id_s),
      .valid   (pick_vld_s)
   );

   // fifo_full gates the transfer, so no write can ever land on a full FIFO
   assign sel_req_s = req[grant_id_r];
   assign xfer_s    = (state_r == GRANT) && sel_req_s && !fifo_full;
   assign grant_id  = grant_id_r;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         grant_id_r  <= GID_RST;
         burst_cnt_r <= '0;
      end else begin
         state_r     <= state_nxt;
         grant_id_r  <= grant_id_nxt;
         burst_cnt_r <= burst_cnt_nxt;
      end
   end

   // next-state: arbitrate in IDLE, count transfers and release in GRANT
   always_comb begin
      state_nxt     = state_r;
      grant_id_nxt  = grant_id_r;
      burst_cnt_nxt = burst_cnt_r;
      case (state_r)
         IDLE: begin
            if (pick_vld_s) begin
               state_nxt     = GRANT;
               grant_id_nxt  = pick_id_s;
               burst_cnt_nxt = '0;
            end else begin
               state_nxt     = IDLE;
            end
         end
         GRANT: begin
            if (!sel_req_s) begin
               state_nxt = IDLE;
            end else if (xfer_s) begin
               if (burst_cnt_r == CNT_LAST) begin
                  state_nxt     = IDLE;
                  burst_cnt_nxt = '0;
               end else begin
                  burst_cnt_nxt = burst_cnt_r + 1'b1;
               end
            end else begin
               state_nxt = GRANT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // outputs: zero-cycle handshake straight from registered state
   always_comb begin
      ack        = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      busy       = (state_r == GRANT);
      case (state_r)
         GRANT: begin
            if (xfer_s) begin
               ack[grant_id_r] = 1'b1;
               fifo_wr_en      = 1'b1;
               fifo_din        = req_data[grant_id_r*DATA_W +: DATA_W];
            end else begin
               fifo_wr_en      = 1'b0;
            end
         end
         IDLE: begin
            fifo_wr_en = 1'b0;
         end
         default: begin
            fifo_wr_en = 1'b0;
         end
      endcase
   end

`ifdef WR_ARB_STATS_EN
   logic [NUM_REQ-1:0][STAT_W-1:0] stat_r;

   // per-producer saturating transfer counters; clear beats increment
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         stat_r <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i] && (stat_r[i] != {STAT_W{1'b1}})) begin
               stat_r[i] <= stat_r[i] + 1'b1;
            end
         end
      end
   end

   assign stat_cnt = stat_r;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of the asyncfifo instance (DEPTH 8) on the write clock domain. It grants one producer at a time for a bounded burst and applies FIFO full backpressure through a valid/ack handshake. It drives the FIFO wr_en/din directly and replaces the single-source timer-driven write enable in the top level.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 8, data width per producer and FIFO din width
BURST_LEN, 4, maximum words per grant before forced re-arbitration (1..16)

Ports:
clk  input  1  write-domain clock
rst_n  input  1  reset, synchronous, active-low
req  input  NUM_REQ  per-producer valid; producer holds data stable while req=1 and ack=0
req_data  input  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-hot or zero; transfer of producer i occurs on an edge where req[i]&ack[i]
fifo_full  input  1  FIFO full flag (write domain)
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DATA_W  FIFO write data
grant_id  output  clog2(NUM_REQ)  current or last granted producer
busy  output  1  1 while in GRANT state

Behaviour:
- States: IDLE, GRANT. Reset: state=IDLE, grant_id=NUM_REQ-1 (so index 0 wins first), burst_cnt=0.
- All outputs are combinational from registered state plus req and fifo_full. Zero-cycle handshake.
- IDLE: if any req bit is set, pick the first set bit searching from grant_id+1 upward, wrapping mod NUM_REQ. At the next edge, load grant_id, clear burst_cnt, and enter GRANT. No ack is given in IDLE. fifo_full does not block arbitration.
- GRANT: ack[grant_id] = req[grant_id] & ~fifo_full. All other ack bits are 0. fifo_wr_en = ack[grant_id]. fifo_din = req_data slice of grant_id, and is 0 when fifo_wr_en=0.
- On a transfer edge, burst_cnt increments. If burst_cnt==BURST_LEN-1, return to IDLE.
- req[grant_id]=0 in GRANT: no write that cycle; return to IDLE at the next edge (grant released).
- fifo_full=1 in GRANT with req held: stay in GRANT, burst_cnt frozen, no ack. The grant is held indefinitely.
- Every release costs one IDLE bubble cycle. Back-to-back bursts therefore sustain BURST_LEN writes per BURST_LEN+1 cycles.
- Overflow guarantee: fifo_wr_en is never 1 while fifo_full=1.
- busy = (state==GRANT). grant_id keeps its value through IDLE.
- rst_n low mid-burst: state is forced to reset values at that edge only. Outputs follow the reset state from the next cycle. A word not acked before that edge is not written.

Optional Feature:
Macro WR_ARB_STATS_EN.
- Defined: adds input stat_clr (1) and output stat_cnt (NUM_REQ*16). stat_cnt holds one 16-bit saturating count of transferred words per producer.
- stat_clr zeroes all counters synchronously and takes priority over a same-cycle increment. Counters reset to 0.
- Not defined: no stat ports and no counter logic.

Decomposition:
- Package fifo_wr_arb_pkg: state encoding (IDLE=1'b0, GRANT=1'b1), STAT_W=16, and a clog2 helper function for GID_W.
- One combinational sub-module, fifo_wr_arb_rr_pick. Inputs: req vector and last-grant index. Outputs: winner index and valid. Implemented as a rotate plus priority encode.

Test Plan:
1. N=4, DATA_W=8, BURST_LEN=4. Only req[2] held, data stepping 10,20,30,40,50,60 per ack. Expect grant_id=2, writes 10,20,30,40 on consecutive edges, one IDLE cycle, then regrant 2 with 50,60.
2. All req held, out of reset. Expect grant order 0,1,2,3,0, four writes each, with exactly one bubble between bursts.
3. req[1] granted, fifo_full=1 for 3 cycles after the 2nd word. Expect ack=0 and fifo_wr_en=0 for those 3 cycles, grant held, burst_cnt=2. Words 3-4 then follow, never a write while full.
4. req[0] drops after 2 words while req[3] is set. Expect release at the next edge, IDLE for 1 cycle, then grant_id=3.
5. rst_n=0 sampled mid-burst at word 2. Expect the next cycle to show busy=0, ack=0, fifo_wr_en=0, grant_id=3, with the next grant going to 0.
6. WR_ARB_STATS_EN defined, scenario 2 run for 2 rounds. Expect stat_cnt=8 per producer. stat_clr together with an ack gives 0.
